// File: rtl/tick_arbiter.sv
// Round-robin tick arbiter: latches per-requester tick events, serves one
// pending requester per cycle, and keeps a wrapping event count per requester
// with sticky overflow and lost-event flags. A free-running divider rotates
// which count is routed to a display port.
module tick_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter int DISP_DIV = 50_000_000,
  localparam int SEL_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int DIV_W   = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       tick,
  input  logic                   clear,
  output logic [N_REQ-1:0]       grant,
  output logic [SEL_W-1:0]       sel,
  output logic [N_REQ*WIDTH-1:0] count,
  output logic [N_REQ-1:0]       overflow,
  output logic [N_REQ-1:0]       lost,
  output logic [SEL_W-1:0]       disp_sel,
  output logic [WIDTH-1:0]       disp_q
);

  logic [N_REQ-1:0] pending;
  logic [SEL_W-1:0] last_granted;
  logic [N_REQ-1:0] win;
  logic [SEL_W-1:0] win_idx;
  logic             found;
  int               idx;
  logic [WIDTH-1:0] cnt [N_REQ];
  logic [DIV_W-1:0] div_cnt;

  // Pick the first pending requester after the last one served.
  always_comb begin
    win     = '0;
    win_idx = last_granted;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_granted) + k) % N_REQ;
      if (!found && pending[SEL_W'(idx)]) begin
        found                = 1'b1;
        win[SEL_W'(idx)]     = 1'b1;
        win_idx              = SEL_W'(idx);
      end
    end
  end

  // Pending events and lost flags; a tick arriving as its requester is served
  // counts as a fresh event rather than a lost one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      lost    <= '0;
    end else if (clear) begin
      pending <= '0;
      lost    <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tick[i]) begin
          pending[i] <= 1'b1;
          if (pending[i] && !win[i]) lost[i] <= 1'b1;
        end else if (win[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Registered grant strobe, selected index and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= '0;
      sel          <= '0;
      last_granted <= SEL_W'(N_REQ - 1);
    end else if (clear) begin
      grant        <= '0;
      last_granted <= SEL_W'(N_REQ - 1);
    end else begin
      grant <= win;
      if (found) begin
        sel          <= win_idx;
        last_granted <= win_idx;
      end
    end
  end

  // Service the granted requester one cycle after its grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      overflow <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          cnt[i] <= cnt[i] + WIDTH'(1);
          if (&cnt[i]) overflow[i] <= 1'b1;
        end
      end
    end
  end

  // Display rotation runs independently of clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      disp_sel <= '0;
    end else if (div_cnt == DIV_W'(DISP_DIV - 1)) begin
      div_cnt  <= '0;
      disp_sel <= (disp_sel == SEL_W'(N_REQ - 1)) ? '0 : disp_sel + SEL_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Flatten the count array and route the displayed count.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_REQ; i++) count[i*WIDTH +: WIDTH] = cnt[i];
    disp_q = cnt[disp_sel];
  end

endmodule

// File: tb/tb_tick_arbiter.sv
// Bench for tick_arbiter: directed scenarios followed by random ticks/clears,
// all compared against an event-level reference model.
module tb_tick_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  tick;
  logic          clear;
  logic [N-1:0]  grant;
  logic [1:0]    sel;
  logic [N*W-1:0] count;
  logic [N-1:0]  overflow;
  logic [N-1:0]  lost;
  logic [1:0]    disp_sel;
  logic [W-1:0]  disp_q;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_pend [N];
  int m_cnt  [N];
  int m_ovf  [N];
  int m_lost [N];
  int m_last, m_gnt, m_sel, m_div, m_dsel;

  tick_arbiter #(.N_REQ(N), .WIDTH(W), .DISP_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .clear(clear),
    .grant(grant), .sel(sel), .count(count), .overflow(overflow),
    .lost(lost), .disp_sel(disp_sel), .disp_q(disp_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
    end
    m_last = N - 1; m_gnt = -1; m_sel = 0; m_div = 0; m_dsel = 0;
  endtask

  task automatic model_step(input logic [N-1:0] t, input logic c);
    int w;
    w = -1;
    if (c) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
      end
      m_last = N - 1;
      m_gnt = -1;
    end else begin
      if (m_gnt >= 0) begin
        m_cnt[m_gnt] = (m_cnt[m_gnt] + 1) % (1 << W);
        if (m_cnt[m_gnt] == 0) m_ovf[m_gnt] = 1;
      end
      for (int k = 1; k <= N; k++)
        if (w < 0 && m_pend[(m_last + k) % N] != 0) w = (m_last + k) % N;
      for (int i = 0; i < N; i++) begin
        if (t[i]) begin
          if (m_pend[i] != 0 && i != w) m_lost[i] = 1;
          m_pend[i] = 1;
        end else if (i == w) begin
          m_pend[i] = 0;
        end
      end
      m_gnt = w;
      if (w >= 0) begin
        m_sel = w;
        m_last = w;
      end
    end
    if (m_div == D - 1) begin
      m_div = 0;
      m_dsel = (m_dsel + 1) % N;
    end else begin
      m_div++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]   eg, eo, el;
    logic [N*W-1:0] ec;
    eg = '0; eo = '0; el = '0; ec = '0;
    if (m_gnt >= 0) eg[m_gnt] = 1'b1;
    for (int i = 0; i < N; i++) begin
      eo[i] = (m_ovf[i] != 0);
      el[i] = (m_lost[i] != 0);
      ec[i*W +: W] = W'(m_cnt[i]);
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("count", 32'(count), 32'(ec));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("lost", 32'(lost), 32'(el));
    chk("disp_sel", 32'(disp_sel), 32'(m_dsel));
    chk("disp_q", 32'(disp_q), 32'(m_cnt[m_dsel]));
  endtask

  // Called between a negedge and the next posedge.
  task automatic run_cycle(input logic [N-1:0] t, input logic c);
    tick = t;
    clear = c;
    @(posedge clk);
    model_step(t, c);
    @(negedge clk);
    tick = '0;
    clear = 1'b0;
    compare_all();
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_lost", 32'(lost), 32'h0);
    chk("rst_dsel", 32'(disp_sel), 32'h0);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    tick = '0;
    clear = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // single tick on requester 2
    run_cycle(4'b0100, 1'b0);
    chk("r29_nogrant", 32'(grant), 32'h0);
    run_cycle(4'b0000, 1'b0);
    chk("r29_grant", 32'(grant), 32'h4);
    chk("r29_sel", 32'(sel), 32'd2);
    run_cycle(4'b0000, 1'b0);
    chk("r29_count", 32'(count[11:8]), 32'd1);

    // all four at once
    run_cycle(4'b0000, 1'b1);
    run_cycle(4'b1111, 1'b0);
    run_cycle(4'b0000, 1'b0);
    chk("r30_g0", 32'(grant), 32'h1);
    run_cycle(4'b0000, 1'b0);
    chk("r30_g1", 32'(grant), 32'h2);
    run_cycle(4'b0000, 1'b0);
    chk("r30_g2", 32'(grant), 32'h4);
    run_cycle(4'b0000, 1'b0);
    chk("r30_g3", 32'(grant), 32'h8);
    run_cycle(4'b0000, 1'b0);
    chk("r30_count", 32'(count), 32'h1111);
    chk("r30_lost", 32'(lost), 32'h0);

    // dropped tick while requester 0 wins
    run_cycle(4'b0000, 1'b1);
    run_cycle(4'b0011, 1'b0);
    run_cycle(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b0);
    chk("r31_lost", 32'(lost), 32'h2);
    chk("r31_count1", 32'(count[7:4]), 32'd1);

    // wrap on requester 3
    run_cycle(4'b0000, 1'b1);
    for (int n = 0; n < 16; n++) begin
      run_cycle(4'b1000, 1'b0);
      run_cycle(4'b0000, 1'b0);
      run_cycle(4'b0000, 1'b0);
    end
    chk("r32_count", 32'(count[15:12]), 32'd0);
    chk("r32_ovf", 32'(overflow), 32'h8);
    run_cycle(4'b1000, 1'b0);
    run_cycle(4'b0000, 1'b0);
    run_cycle(4'b0000, 1'b0);
    chk("r32_count17", 32'(count[15:12]), 32'd1);
    chk("r32_ovf17", 32'(overflow), 32'h8);

    // clear against a tick and a due increment
    run_cycle(4'b0010, 1'b0);
    run_cycle(4'b0000, 1'b0);
    chk("r33_pre_grant", 32'(grant), 32'h2);
    run_cycle(4'b0001, 1'b1);
    chk("r33_count", 32'(count), 32'h0);
    chk("r33_grant", 32'(grant), 32'h0);
    chk("r33_flags", 32'({overflow, lost}), 32'h0);
    run_cycle(4'b0000, 1'b0);
    run_cycle(4'b0000, 1'b0);
    chk("r33_nopend", 32'(grant), 32'h0);

    // random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] t;
      logic c;
      t = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      c = ($urandom_range(0, 39) == 0);
      if (n == 200) reset_pulse();
      run_cycle(t, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
